// File: rtl/mod_mult_seq_if.sv
// rtl/mod_mult_seq_if.sv - operand/result handshake bundle for mod_mult_seq
//
// Purpose: groups the operand-side and result-side valid/ready handshakes of
// the sequential modular multiplier so both ends share one declaration.
//
// Signals:
//   in_valid  upstream -> block   operands a, b, k are valid
//   in_ready  block -> upstream   block can accept operands
//   a, b      upstream -> block   multiplicand / multiplier (N bits)
//   k         upstream -> block   modulus offset, M = 2^N - k (N bits)
//   out_valid block -> consumer   result valid
//   out_ready consumer -> block   consumer accepts result
//   result    block -> consumer   (a*b) mod M (N bits)
//   err       block -> consumer   operand range error flag
//
// Modports: master = the environment driving operands and consuming results,
//           slave  = the multiplier itself.
interface mod_mult_seq_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] k;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         err;

    modport master (
        output in_valid, a, b, k, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, a, b, k, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/mod_mult_seq.sv
// rtl/mod_mult_seq.sv - sequential double-and-add modular multiplier
//
// Purpose: computes result = (a * b) mod M with M = 2^N - k. After an operand
// set is accepted, one bit of b is consumed per clock, MSB first; each step is
// acc = 2*acc (mod M) followed by a conditional + a (mod M). The result is
// presented N cycles after the accept edge and held until taken.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mod_mult_seq_if.slave: in_valid/in_ready/a/b/k operand handshake,
//          out_valid/out_ready/result/err result handshake
//
// Build option: MOD_MULT_RANGE_CHECK_EN
//   defined   - operands with a >= M, b >= M or k = 2^N-1 are rejected at the
//               accept edge: result 0, err 1, out_valid one cycle later.
//   undefined - no checking; err is tied to 0.
module mod_mult_seq #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_mult_seq_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  k_reg;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_next;
    logic [N-1:0]  dbl;
    logic [CW-1:0] cnt;
    logic [N-1:0]  result_reg;
    logic          accept;
    logic          range_err;

    // x + y mod M for x, y < M. s >= M exactly when s + k reaches 2^N, so the
    // reduced value is simply the low N bits of s + k. Two guard bits keep the
    // compare exact even for out-of-range operands.
    function automatic logic [N-1:0] mod_add(
        input logic [N-1:0] x,
        input logic [N-1:0] y,
        input logic [N-1:0] kk
    );
        logic [N+1:0] s;
        logic [N+1:0] sk;
        s  = {2'b00, x} + {2'b00, y};
        sk = s + {2'b00, kk};
        mod_add = (sk[N+1:N] != 2'b00) ? sk[N-1:0] : s[N-1:0];
    endfunction

    assign accept = bus.in_valid && (state == IDLE);

    // One double-and-add step driven by the current bit of the multiplier.
    always_comb begin
        dbl      = mod_add(acc, acc, k_reg);
        acc_next = b_reg[cnt] ? mod_add(dbl, a_reg, k_reg) : dbl;
    end

`ifdef MOD_MULT_RANGE_CHECK_EN
    logic [N:0] a_plus_k;
    logic [N:0] b_plus_k;
    logic       err_reg;

    // a >= M is the same as a + k carrying out of N bits.
    always_comb begin
        a_plus_k  = {1'b0, bus.a} + {1'b0, bus.k};
        b_plus_k  = {1'b0, bus.b} + {1'b0, bus.k};
        range_err = a_plus_k[N] || b_plus_k[N] || (&bus.k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (accept && range_err) begin
            err_reg <= 1'b1;
        end else if ((state == DONE) && bus.out_ready) begin
            err_reg <= 1'b0;
        end
    end

    assign bus.err = err_reg;
`else
    assign range_err = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = range_err ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs come from the state register only; in_ready is also
    // held low for as long as reset is asserted.
    always_comb begin
        bus.in_ready  = rst_n && (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Operand capture and datapath. A rejected operand set leaves result at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            k_reg      <= '0;
            acc        <= '0;
            cnt        <= '0;
            result_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        k_reg <= bus.k;
                        acc   <= '0;
                        cnt   <= CW'(N - 1);
                        if (range_err) begin
                            result_reg <= '0;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        result_reg <= acc_next;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_reg;
endmodule

// File: tb/tb_mod_mult_seq.sv
// tb/tb_mod_mult_seq.sv - scoreboard bench for mod_mult_seq at N=7
module tb_mod_mult_seq;
    localparam int N = 7;

    typedef struct {
        int res;
        int err;
        bit chk_res;
        int lat;
        int acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   stall_ctl = 2;
    bit   seen = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mod_mult_seq_if #(.N(N)) bus ();

    mod_mult_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure: 0 = random, 1 = always stall, 2 = always ready.
    always @(posedge clk) begin
        #2;
        case (stall_ctl)
            0:       bus.out_ready = ($urandom_range(0, 3) != 0);
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: first sight of out_valid checks latency, handshake pops and
    // compares the result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
                if (!seen) chk("unexpected_out_valid", 1, 0);
                seen = 1'b1;
                if (bus.out_ready) seen = 1'b0;
            end else begin
                if (!seen) begin
                    chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                    seen = 1'b1;
                end
                if (bus.out_ready) begin
                    mon_e = sb.pop_front();
                    if (mon_e.chk_res) chk("result", bus.result, mon_e.res);
                    chk("err", bus.err, mon_e.err);
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int a, input int b, input int k, input bit sync, output int waited);
        exp_t e;
        int   m;
        m = (1 << N) - k;
        if (sync) @(negedge clk);
        bus.a        = N'(a);
        bus.b        = N'(b);
        bus.k        = N'(k);
        bus.in_valid = 1'b1;
        waited       = 0;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        if (a >= m || b >= m || k > (1 << N) - 2) begin
`ifdef MOD_MULT_RANGE_CHECK_EN
            e.res = 0; e.err = 1; e.chk_res = 1'b1; e.lat = 1;
`else
            e.res = 0; e.err = 0; e.chk_res = 1'b0; e.lat = N;
`endif
        end else begin
            e.res = (a * b) % m; e.err = 0; e.chk_res = 1'b1; e.lat = N;
        end
        sb.push_back(e);
        // Junk operands with in_valid still high while busy must be ignored.
        bus.a = N'($urandom);
        bus.b = N'($urandom);
        bus.k = N'($urandom);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int w;
        int n;
        int hold;
        int k;
        int m;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.k = '0;

        repeat (2) @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_err", bus.err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_out_valid", bus.out_valid, 0);

        // Directed operand sets.
        issue(100, 3, 3, 1'b1, w);
        issue(124, 124, 3, 1'b1, w);
        issue(0, 77, 3, 1'b1, w);
        issue(127, 127, 0, 1'b1, w);
        issue(1, 1, 126, 1'b1, w);
        issue(0, 0, 0, 1'b1, w);
        drain();

        // Held result under back-pressure, then earliest re-accept.
        stall_ctl = 1;
        issue(17, 9, 3, 1'b1, w);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_out_valid_seen", bus.out_valid, 1);
        hold = bus.result;
        chk("stall_value", hold, 28);
        repeat (5) begin
            @(negedge clk);
            chk("stall_result_hold", bus.result, hold);
            chk("stall_out_valid_hold", bus.out_valid, 1);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        stall_ctl = 2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_ready && n < 10);
        @(negedge clk);
        chk("post_take_out_valid", bus.out_valid, 0);
        chk("post_take_in_ready", bus.in_ready, 1);
        issue(41, 50, 3, 1'b0, w);
        chk("accept_next_edge", w, 0);
        drain();

        // Asynchronous reset in the middle of a calculation.
        issue(33, 44, 3, 1'b1, w);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_out_valid", bus.out_valid, 0);
        chk("midreset_in_ready", bus.in_ready, 0);
        chk("midreset_result", bus.result, 0);
        chk("midreset_err", bus.err, 0);
        repeat (2) @(negedge clk);
        chk("midreset_out_valid_hold", bus.out_valid, 0);
        rst_n = 1'b1;
        issue(5, 6, 3, 1'b1, w);
        drain();

        // Out-of-range operand.
        issue(126, 2, 3, 1'b1, w);
        drain();

        // Randomized in-range traffic with random back-pressure.
        stall_ctl = 0;
        repeat (40) begin
            k = $urandom_range(0, (1 << N) - 2);
            m = (1 << N) - k;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue($urandom_range(0, m - 1), $urandom_range(0, m - 1), k, 1'b1, w);
        end
        stall_ctl = 2;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
